seq_chunk_adder: RTL and testbench



---
 rtl/seq_chunk_adder.sv | 136 +++++++++++++
 tb/tb_seq_chunk_adder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// Purpose : multi-cycle a + b + cin adder, one CHUNK-bit slice per clock with a registered ripple carry.
// Latency : result valid N = WIDTH/CHUNK cycles after acceptance; one operation every N+2 cycles.
// Backpr. : out_valid/sum/cout/ovf hold while out_ready is low; no new operands are taken until the result is popped.
//
// Ports:
//   clk, rst              - clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   - operand handshake; in_ready is high only in IDLE
//   a, b, cin             - operands, sampled only on the accepting edge
//   out_valid / out_ready - result handshake; out_valid is high only in DONE
//   sum, cout, ovf        - (a+b+cin) mod 2^WIDTH, carry out of the MSB, signed overflow
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic [IDX_W-1:0] k;
  logic             cout_r;
  logic             ovf_r;

  // Slice datapath: select slice k of both operands by shifting it down to bit 0.
  logic [31:0]      base;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   sl_sum;
  logic [WIDTH-1:0] slice_mask;
  logic [WIDTH-1:0] sum_ins;
  logic             ovf_last;

  assign base   = 32'(k) * 32'(CHUNK);
  assign a_sl   = CHUNK'(a_r >> base);
  assign b_sl   = CHUNK'(b_r >> base);
  assign sl_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_r};

  // Merge the new slice into the result register, leaving the other slices untouched.
  assign slice_mask = WIDTH'({CHUNK{1'b1}});
  assign sum_ins    = (sum_r & ~(slice_mask << base))
                    | (WIDTH'(sl_sum[CHUNK-1:0]) << base);

  // On the last slice, sl_sum[CHUNK-1] is the result MSB. Like-signed operands
  // producing an opposite-signed result is signed overflow (cin included).
  assign ovf_last = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sl_sum[CHUNK-1] != a_r[WIDTH-1]);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = RUN;
      RUN:     if (k == LAST_IDX) state_nxt = DONE;
      DONE:    if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Operand capture, slice-by-slice accumulation and flag capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      k       <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            k       <= '0;
          end
        end
        RUN: begin
          sum_r   <= sum_ins;
          carry_r <= sl_sum[CHUNK];
          k       <= k + IDX_W'(1);
          if (k == LAST_IDX) begin
            cout_r <= sl_sum[CHUNK];
            ovf_r  <= ovf_last;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake flags decoded from registered state only: no in_valid->in_ready
  // or out_ready->out_valid combinational path.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Purpose : directed bench for seq_chunk_adder, 32/8 and 16/16 configurations.
// Ports   : none (top-level bench); drives both instances from one clock and reset.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=32, CHUNK=8 instance
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // WIDTH=16, CHUNK=16 instance (single-slice case)
  logic        w16_in_valid, w16_in_ready, w16_cin, w16_out_valid, w16_out_ready, w16_cout, w16_ovf;
  logic [15:0] w16_a, w16_b, w16_sum;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(w16_in_valid), .in_ready(w16_in_ready),
    .a(w16_a), .b(w16_b), .cin(w16_cin),
    .out_valid(w16_out_valid), .out_ready(w16_out_ready),
    .sum(w16_sum), .cout(w16_cout), .ovf(w16_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One operation on the 32-bit instance; called at a negedge with the DUT idle
  // and out_ready high. Operands are scrambled right after acceptance.
  task automatic run_op(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                        input logic xc, input logic [31:0] es, input logic ec, input logic eo);
    int lat;
    check({tag, " in_ready"}, in_ready, 1);
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = 32'h12345678; b = 32'h9ABCDEF0; cin = ~xc;
    check({tag, " busy"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 4);
    check({tag, " sum"}, sum, es);
    check({tag, " cout"}, cout, ec);
    check({tag, " ovf"}, ovf, eo);
    @(negedge clk);
    check({tag, " popped"}, {out_valid, in_ready}, 2'b01);
  endtask

  task automatic run_op16(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                          input logic xc, input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    w16_a = xa; w16_b = xb; w16_cin = xc; w16_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w16_in_valid = 1'b0; w16_a = 16'hA5A5; w16_b = 16'h5A5A; w16_cin = ~xc;
    lat = 0;
    while (!w16_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 1);
    check({tag, " sum"}, w16_sum, es);
    check({tag, " cout"}, w16_cout, ec);
    check({tag, " ovf"}, w16_ovf, eo);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          w;
    int          acc_cyc;
    int          prev_cyc;
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] exp_full;
    logic [33:0] exp_sgn;

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    w16_in_valid = 1'b0; w16_a = '0; w16_b = '0; w16_cin = 1'b0; w16_out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    check("reset ovf", ovf, 0);
    check("reset16 in_ready", w16_in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Carry ripples through every slice
    run_op("ffffffff+1", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    // Signed overflow, positive and negative
    run_op("7fffffff+1", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op("80000000+80000000", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
    // cin into slice 0 carries into slice 1; a changes during RUN
    run_op("ff+0+cin", 32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 1'b0, 1'b0);
    // Overflow caused by cin alone
    run_op("7fffffff+0+cin", 32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1);

    // Backpressure: hold out_ready low 5 cycles in DONE while pulsing in_valid
    out_ready = 1'b0;
    a = 32'd1; b = 32'd2; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 32'd10; b = 32'd20; in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      @(posedge clk);
      @(negedge clk);
      check("bp out_valid held", out_valid, 1);
      check("bp sum held", sum, 32'd3);
      check("bp cout held", cout, 0);
      check("bp in_ready low", in_ready, 0);
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp pop in_ready", in_ready, 1);
    check("bp pop out_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = 32'h0; b = 32'h0;
    check("bp accepted after pop", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp2 latency", lat, 4);
    check("bp2 sum", sum, 32'd30);
    @(negedge clk);

    // Reset mid-operation, two RUN cycles in
    a = 32'h11111111; b = 32'h22222222; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort sum", sum, 0);
    check("abort in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort no result", out_valid, 0);
    run_op("5+7 after reset", 32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 1'b0);

    // 20 random back-to-back operations, in_valid and out_ready held high
    prev_cyc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1));
      w = 0;
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      a = ra; b = rb; cin = rc;
      @(posedge clk);
      acc_cyc = cyc;
      if (i > 0) check("rnd period", acc_cyc - prev_cyc, 6);
      prev_cyc = acc_cyc;
      @(negedge clk);
      a = ~ra; b = ~rb; cin = ~rc;
      w = 0;
      while (!out_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      exp_full = {1'b0, ra} + {1'b0, rb} + 33'(rc);
      exp_sgn  = {{2{ra[31]}}, ra} + {{2{rb[31]}}, rb} + 34'(rc);
      check("rnd sum", sum, exp_full[31:0]);
      check("rnd cout", cout, exp_full[32]);
      check("rnd ovf", ovf, exp_sgn[32] != exp_sgn[31]);
      @(negedge clk);
    end
    in_valid = 1'b0;

    // WIDTH=16, CHUNK=16: one-cycle RUN, overflow at bit 15
    run_op16("w16 7fff+1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op16("w16 ffff+1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op16("w16 8000+ffff", 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    run_op16("w16 7ffe+0+cin", 16'h7FFE, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b0);
    run_op16("w16 7fff+0+cin", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
